// File: rtl/la_arb3rr_pkg.sv
// Shared types and helpers for the la_arb3rr round-robin arbiter.
// Holds the IDLE/BUSY state encoding and the hold-counter width rule.
package la_arb3rr_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  function automatic int cnt_width(input int maxhold);
    int w;
    w = $clog2(maxhold + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/la_arb3rr_rrpick.sv
// Combinational rotate-priority picker: first set bit of cand searching
// upward from (last+1) mod N with wrap-around.
module la_rrpick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  cand,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  win_oh,
  output logic [IW-1:0] win_id,
  output logic          any
);

  always_comb begin
    int idx;
    logic [IW-1:0] idx_w;
    win_oh = '0;
    win_id = '0;
    any    = 1'b0;
    idx    = 0;
    idx_w  = '0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(last) + k;
      if (idx >= N) idx = idx - N;
      idx_w = IW'(idx);
      if (!any && cand[idx_w]) begin
        any           = 1'b1;
        win_oh[idx_w] = 1'b1;
        win_id        = idx_w;
      end
    end
  end

endmodule

// File: rtl/la_arb3rr.sv
// Round-robin arbiter with enable-gated, registered, lockable grant.
// The holder keeps the resource until done, withdraw, or hold-limit preempt.
module la_arb3rr
  import la_arb3rr_pkg::*;
#(
  parameter int    N       = 3,
  parameter int    MAXHOLD = 0,
  parameter string PROP    = "DEFAULT"
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [N-1:0]         req,
  input  logic                 done,
  output logic [N-1:0]         grant,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy
);

  localparam int IW = $clog2(N);
  localparam int CW = cnt_width(MAXHOLD);

  // PROP is carried for netlist annotation only.
  if (PROP == "") begin : g_prop_empty
  end

  state_t          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [IW-1:0]   id_q, id_d;
  logic [IW-1:0]   last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            withdraw, preempt, release_c;
  logic [N-1:0]    cand;
  logic [N-1:0]    pick_oh;
  logic [IW-1:0]   pick_id;
  logic            pick_any;

  la_rrpick #(.N(N), .IW(IW)) u_pick (
    .cand   (cand),
    .last   (last_q),
    .win_oh (pick_oh),
    .win_id (pick_id),
    .any    (pick_any)
  );

  always_comb begin
    withdraw  = (state_q == ST_BUSY) && !(|(req & grant_q));
    preempt   = (MAXHOLD != 0) && (state_q == ST_BUSY) &&
                (cnt_q == CW'(MAXHOLD)) && (|(req & ~grant_q));
    release_c = done || withdraw || preempt;
    // The holder's own bit is only dropped from the candidates when it withdrew.
    cand      = en ? (req & ~(withdraw ? grant_q : '0)) : '0;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    id_d    = id_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_BUSY;
          grant_d = pick_oh;
          id_d    = pick_id;
          last_d  = pick_id;
          cnt_d   = CW'(1);
        end
      end
      ST_BUSY: begin
        if (release_c) begin
          if (pick_any) begin
            grant_d = pick_oh;
            id_d    = pick_id;
            last_d  = pick_id;
            cnt_d   = CW'(1);
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
            id_d    = '0;
            cnt_d   = '0;
          end
        end else if ((MAXHOLD != 0) && (cnt_q != CW'(MAXHOLD))) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      id_q    <= '0;
      last_q  <= IW'(N - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant     = grant_q;
  assign gnt_id    = id_q;
  assign gnt_valid = |grant_q;
  assign busy      = (state_q == ST_BUSY);

endmodule

// File: tb/tb_la_arb3rr.sv
// Directed self-checking bench for la_arb3rr (N=3); one DUT with MAXHOLD=4
// and one with MAXHOLD=0 share the same stimulus.
module tb_la_arb3rr;

  logic       clk = 1'b0;
  logic       reset, en, done;
  logic [2:0] req;

  logic [2:0] g4, g0;
  logic       v4, v0, b4, b0;
  logic [1:0] id4, id0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  la_arb3rr #(.N(3), .MAXHOLD(4), .PROP("DEFAULT")) dut4 (
    .clk(clk), .reset(reset), .en(en), .req(req), .done(done),
    .grant(g4), .gnt_valid(v4), .gnt_id(id4), .busy(b4)
  );

  la_arb3rr #(.N(3), .MAXHOLD(0), .PROP("DEFAULT")) dut0 (
    .clk(clk), .reset(reset), .en(en), .req(req), .done(done),
    .grant(g0), .gnt_valid(v0), .gnt_id(id0), .busy(b0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; req = 3'b000; done = 1'b0;
    tick(); tick();
    reset = 1'b0;
    checks++; if (g4 !== 3'b000) begin errors++; $display("FAIL reset_grant: got %b want 000", g4); end
    checks++; if (v4 !== 1'b0)   begin errors++; $display("FAIL reset_valid: got %b want 0", v4); end
    checks++; if (id4 !== 2'd0)  begin errors++; $display("FAIL reset_id: got %0d want 0", id4); end
    checks++; if (b4 !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b want 0", b4); end
    checks++; if (g0 !== 3'b000 || b0 !== 1'b0) begin errors++; $display("FAIL reset_dut0: got %b/%b want 000/0", g0, b0); end
  endtask

  task automatic test_reset_priority();
    req = 3'b111; en = 1'b1;
    tick();
    checks++; if (g4 !== 3'b001 || id4 !== 2'd0) begin errors++; $display("FAIL prio_first: got %b id %0d want 001 id 0", g4, id4); end
    checks++; if (v4 !== 1'b1 || b4 !== 1'b1) begin errors++; $display("FAIL prio_valid: got %b/%b want 1/1", v4, b4); end
    tick(); tick();
    checks++; if (g4 !== 3'b001) begin errors++; $display("FAIL prio_hold: got %b want 001", g4); end
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++; if (g4 !== 3'b010 || id4 !== 2'd1) begin errors++; $display("FAIL prio_after_done: got %b id %0d want 010 id 1", g4, id4); end
  endtask

  task automatic test_rotation();
    logic [2:0] exp_g [3];
    logic [1:0] exp_id [3];
    logic [2:0] prev;
    exp_g[0] = 3'b100; exp_id[0] = 2'd2;
    exp_g[1] = 3'b001; exp_id[1] = 2'd0;
    exp_g[2] = 3'b010; exp_id[2] = 2'd1;
    prev = 3'b010;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (g4 !== prev) begin errors++; $display("FAIL rot_hold%0d: got %b want %b", i, g4, prev); end
      done = 1'b1;
      tick();
      done = 1'b0;
      checks++; if (g4 !== exp_g[i] || id4 !== exp_id[i] || v4 !== 1'b1) begin
        errors++; $display("FAIL rot_next%0d: got %b id %0d v %b want %b id %0d v 1", i, g4, id4, v4, exp_g[i], exp_id[i]);
      end
      prev = exp_g[i];
    end
    req = 3'b000;
    tick();
    checks++; if (g4 !== 3'b000 || b4 !== 1'b0) begin errors++; $display("FAIL rot_idle: got %b busy %b want 000 busy 0", g4, b4); end
  endtask

  task automatic test_enable();
    en = 1'b0; req = 3'b100;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (g4 !== 3'b000) begin errors++; $display("FAIL en_block%0d: got %b want 000", i, g4); end
    end
    en = 1'b1;
    tick();
    checks++; if (g4 !== 3'b100 || id4 !== 2'd2) begin errors++; $display("FAIL en_grant: got %b id %0d want 100 id 2", g4, id4); end
    en = 1'b0;
    tick();
    checks++; if (g4 !== 3'b100 || b4 !== 1'b1) begin errors++; $display("FAIL en_low_hold: got %b busy %b want 100 busy 1", g4, b4); end
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++; if (g4 !== 3'b000 || b4 !== 1'b0) begin errors++; $display("FAIL en_low_release: got %b busy %b want 000 busy 0", g4, b4); end
    tick();
    checks++; if (g4 !== 3'b000) begin errors++; $display("FAIL en_low_stay: got %b want 000", g4); end
  endtask

  task automatic test_withdraw();
    req = 3'b010; en = 1'b1;
    tick();
    checks++; if (g4 !== 3'b010 || id4 !== 2'd1) begin errors++; $display("FAIL wd_grant1: got %b id %0d want 010 id 1", g4, id4); end
    req = 3'b001;
    tick();
    checks++; if (g4 !== 3'b001 || id4 !== 2'd0) begin errors++; $display("FAIL wd_switch: got %b id %0d want 001 id 0", g4, id4); end
    req = 3'b000;
    tick();
    checks++; if (g4 !== 3'b000 || b4 !== 1'b0 || id4 !== 2'd0) begin errors++; $display("FAIL wd_idle: got %b busy %b id %0d want 000 0 0", g4, b4, id4); end
  endtask

  task automatic test_hold_limit();
    req = 3'b001;
    tick();
    checks++; if (g4 !== 3'b001 || g0 !== 3'b001) begin errors++; $display("FAIL hl_start: got %b/%b want 001/001", g4, g0); end
    req = 3'b011;
    for (int c = 1; c <= 20; c++) begin
      tick();
      checks++; if (g0 !== 3'b001) begin errors++; $display("FAIL hl_unlimited%0d: got %b want 001", c, g0); end
      if (c < 4) begin
        checks++; if (g4 !== 3'b001) begin errors++; $display("FAIL hl_hold%0d: got %b want 001", c, g4); end
      end else if (c == 4) begin
        checks++; if (g4 !== 3'b010 || id4 !== 2'd1) begin errors++; $display("FAIL hl_preempt: got %b id %0d want 010 id 1", g4, id4); end
      end
    end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1; req = 3'b100; en = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    checks++; if (g4 !== 3'b100) begin errors++; $display("FAIL rm_setup: got %b want 100", g4); end
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (g4 !== 3'b000 || v4 !== 1'b0 || id4 !== 2'd0 || b4 !== 1'b0) begin
      errors++; $display("FAIL rm_drop: got %b v %b id %0d b %b want 000 0 0 0", g4, v4, id4, b4);
    end
    req = 3'b111;
    tick();
    checks++; if (g4 !== 3'b001 || id4 !== 2'd0) begin errors++; $display("FAIL rm_regrant: got %b id %0d want 001 id 0", g4, id4); end
  endtask

  task automatic test_back_to_back();
    req = 3'b001; done = 1'b1;
    tick();
    done = 1'b0;
    checks++; if (g4 !== 3'b001 || v4 !== 1'b1) begin errors++; $display("FAIL b2b_selfregrant: got %b v %b want 001 v 1", g4, v4); end
    req = 3'b011;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c < 4) begin
        checks++; if (g4 !== 3'b001) begin errors++; $display("FAIL b2b_restart%0d: got %b want 001", c, g4); end
      end else begin
        checks++; if (g4 !== 3'b010) begin errors++; $display("FAIL b2b_preempt: got %b want 010", g4); end
      end
    end
    tick(); tick(); tick();
    checks++; if (g4 !== 3'b010) begin errors++; $display("FAIL b2b_sat_hold: got %b want 010", g4); end
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++; if (g4 !== 3'b001 || id4 !== 2'd0) begin errors++; $display("FAIL b2b_done_preempt: got %b id %0d want 001 id 0", g4, id4); end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; req = 3'b000; done = 1'b0;
    test_reset();
    test_reset_priority();
    test_rotation();
    test_enable();
    test_withdraw();
    test_hold_limit();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
